multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the multicycle RV32I datapath that drives the ALU's ALUControl port plus all datapath mux selects and write enables. A Moore main FSM sequences each instruction through fetch/decode/execute/writeback. A small ALU decoder maps ALUOp/funct fields onto the ALU's 3-bit op encoding. Memory accesses stall on a MemReady handshake, so variable-latency memory is supported.

Parameters:
none (all encodings fixed in package)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
op  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  0=PC, 1=ALUOut to memory address
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction/OldPC register enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 (A)
ALUSrcB  output  2  00=rs2 (WriteData), 01=ImmExt, 10=const 4
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
RegWrite  output  1  register file write enable
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt

Behaviour:
- Reset: async on reset_n low -> state FETCH; while reset_n low PCWrite, IRWrite, MemWrite, RegWrite forced 0; selects take FETCH values. First FETCH after release of reset_n.
- Outputs combinational from state (Moore), except PCWrite in BEQ (uses Zero) and FETCH/MEMWRITE gating (uses MemReady).
- States and outputs (unlisted enables 0, unlisted selects 00):
  FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=MemReady. Stay while MemReady=0; -> DECODE when 1.
  DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). lw/sw -> MEMADR; R -> EXECUTER; I-ALU -> EXECUTEI; beq -> BEQ; jal -> JAL; other -> see Optional Feature.
  MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD; sw -> MEMWRITE.
  MEMREAD: AdrSrc=1, ResultSrc=00. Stay until MemReady; -> MEMWB.
  MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until MemReady; -> FETCH.
  EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
  JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- ImmSrc combinational from op in every state: lw/I 00, sw 01, beq 10, jal 11, other 00.
- ALU decoder: ALUOp 00 -> 000; 01 -> 001; 10 by funct3: 000 -> 001 if op[5]&funct7b5 else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
- Op/funct inputs sampled only in DECODE/MEMADR; IR is stable after FETCH, so no internal latching.
- Reset mid-instruction (any state, incl. MemWrite held high): immediate return to FETCH, all enables 0 asynchronously.

Optional Feature:
ILLEGAL_TRAP_EN. Defined: unknown opcode in DECODE -> TRAP state; TRAP is absorbing until reset, all enables 0, extra output IllegalInstr (1 bit) = 1 in TRAP, 0 otherwise and 0 during reset. Undefined: no TRAP state or port; unknown opcode DECODE -> FETCH (executes as NOP, PC already advanced).

Decomposition:
- Package riscv_ctrl_pkg: state enum, opcode localparams, ALUControl codes, ALUOp, ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings.
- Sub-module aludec (ALUOp, funct3, op[5], funct7b5 -> ALUControl), instantiated once. FSM and ImmSrc decode stay in top.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MemReady=1 -> FETCH,DECODE,EXECUTER,ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB; 4 cycles.
- sub (f7b5 1) and slt/or/and (f3 010/110/111) -> ALUControl 001/101/011/010 in EXECUTER; addi with f7b5=1 -> 000.
- lw with MemReady low 3 cycles in MEMREAD -> stays MEMREAD 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1; FETCH with MemReady=0 holds IRWrite=PCWrite=0.
- sw with MemReady low 2 cycles -> MemWrite=1, AdrSrc=1 for 3 consecutive cycles, then FETCH; RegWrite never 1.
- beq Zero=1 -> PCWrite=1 in BEQ, ALUControl=001; Zero=0 -> PCWrite=0; jal -> PCWrite=1 in JAL, then ALUWB RegWrite=1.
- reset_n low mid-MEMWRITE -> MemWrite drops to 0 without a clock edge; after release, state FETCH; opcode 1111111 -> TRAP with IllegalInstr=1 (ILLEGAL_TRAP_EN) else back to FETCH next cycle.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU op codes and datapath select encodings. ILLEGAL_TRAP_EN adds the TRAP state.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps ALUOp plus instruction funct fields onto the ALU op code.
module aludec
  import riscv_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output logic [2:0]  alucontrol
);

  always_comb begin
    // NOTE: default assignment first so every path drives alucontrol; no latch.
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;  // only R-type sub
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM for the multicycle RV32I datapath with MemReady stalls.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes in an absorbing TRAP state.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
`ifdef ILLEGAL_TRAP_EN
  output logic       IllegalInstr,
`endif
  output logic [2:0] ALUControl
);

  state_t state, state_next;
  aluop_t aluop;
  logic   pcw, mw, irw, rw;

  // NOTE: sequential state uses non-blocking assignment; comb logic uses blocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (MemReady) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;  // unknown opcode runs as a NOP
`endif
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (MemReady) state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_next = S_TRAP;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcw       = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irw       = MemReady;
        pcw       = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        rw        = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:    rw = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_SUB;
        pcw     = Zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pcw     = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked by reset_n itself so they drop without waiting for a clock.
  assign PCWrite  = pcw & reset_n;
  assign MemWrite = mw  & reset_n;
  assign IRWrite  = irw & reset_n;
  assign RegWrite = rw  & reset_n;
  assign ImmSrc   = imm_src(op);

`ifdef ILLEGAL_TRAP_EN
  assign IllegalInstr = (state == S_TRAP) && reset_n;
`endif

  aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected output
// vectors go through a scoreboard queue and are compared at mid-cycle.
module tb_multicycle_controller;

  typedef enum int {
    B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB, B_MEMWRITE,
    B_EXECR, B_EXECI, B_ALUWB, B_BEQ, B_JAL, B_TRAP
  } bst_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [16:0] exp_q[$];

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
`ifdef ILLEGAL_TRAP_EN
    .IllegalInstr (illegal_w),
`endif
    .ALUControl (ALUControl)
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference outputs written straight from the state/output table.
  function automatic logic [16:0] expect_vec(input bst_t s, input logic rst_active);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm, aop;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, ill} = '0;
    {rs, sa, sb, aop} = '0;
    case (s)
      B_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = MemReady; pcw = MemReady; end
      B_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      B_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      B_MEMREAD:  adr = 1'b1;
      B_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      B_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      B_EXECR:    begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
      B_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      B_ALUWB:    rw = 1'b1;
      B_BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = Zero; end
      B_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      B_TRAP:     ill = 1'b1;
      default: ;
    endcase
    if (rst_active) {pcw, mw, irw, rw, ill} = '0;
    if (aop == 2'b00)      alu = 3'b000;
    else if (aop == 2'b01) alu = 3'b001;
    else if (funct3 == 3'b010) alu = 3'b101;
    else if (funct3 == 3'b110) alu = 3'b011;
    else if (funct3 == 3'b111) alu = 3'b010;
    else if (funct3 == 3'b000 && op[5] && funct7b5) alu = 3'b001;
    else alu = 3'b000;
    if (op == 7'b0100011)      imm = 2'b01;
    else if (op == 7'b1100011) imm = 2'b10;
    else if (op == 7'b1101111) imm = 2'b11;
    else                       imm = 2'b00;
    return {ill, pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {illegal_w, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, RegWrite, ALUControl};
  endfunction

  task automatic compare_head(input string tag);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {15'd0, dut_vec()}, {15'd0, e});
    end
  endtask

  // Called at a falling edge: drive, push expectation, compare, advance one cycle.
  task automatic step(input bst_t s, input logic mr, input logic z = 1'b0);
    MemReady = mr;
    Zero     = z;
    #1;
    exp_q.push_back(expect_vec(s, 1'b0));
    compare_head($sformatf("%s@%0d", s.name(), cyc));
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic r_type(input logic [2:0] f3, input logic f7);
    set_instr(7'b0110011, f3, f7);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_EXECR, 1'b1);
    step(B_ALUWB, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    MemReady = 1'b1;
    Zero     = 1'b0;
    #3;
    exp_q.push_back(expect_vec(B_FETCH, 1'b1));
    compare_head("reset_hold");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // R-type: add, sub, slt, or, and
    r_type(3'b000, 1'b0);
    r_type(3'b000, 1'b1);
    r_type(3'b010, 1'b0);
    r_type(3'b110, 1'b0);
    r_type(3'b111, 1'b0);

    // addi with funct7b5 set must still add
    set_instr(7'b0010011, 3'b000, 1'b1);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_EXECI, 1'b1);
    step(B_ALUWB, 1'b1);

    // lw: fetch stalls twice, MEMREAD stalls three cycles
    set_instr(7'b0000011, 3'b010, 1'b0);
    step(B_FETCH, 1'b0);
    step(B_FETCH, 1'b0);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_MEMADR, 1'b1);
    for (int i = 0; i < 3; i++) step(B_MEMREAD, 1'b0);
    step(B_MEMREAD, 1'b1);
    step(B_MEMWB, 1'b1);

    // sw: MemWrite held three cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_MEMADR, 1'b1);
    step(B_MEMWRITE, 1'b0);
    step(B_MEMWRITE, 1'b0);
    step(B_MEMWRITE, 1'b1);

    // beq taken / not taken, then jal
    set_instr(7'b1100011, 3'b000, 1'b0);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_BEQ, 1'b1, 1'b1);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_BEQ, 1'b1, 1'b0);
    set_instr(7'b1101111, 3'b000, 1'b0);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_JAL, 1'b1);
    step(B_ALUWB, 1'b1);

    // reset asserted in the middle of a stalled store
    set_instr(7'b0100011, 3'b010, 1'b0);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
    step(B_MEMADR, 1'b1);
    MemReady = 1'b0;
    #1;
    exp_q.push_back(expect_vec(B_MEMWRITE, 1'b0));
    compare_head("memwrite_before_reset");
    #1;
    reset_n = 1'b0;
    #1;
    check("memwrite_async_drop", {31'd0, MemWrite}, 32'd0);
    exp_q.push_back(expect_vec(B_FETCH, 1'b1));
    compare_head("mid_reset_vector");
    @(negedge clk);
    reset_n = 1'b1;

    // unknown opcode
    set_instr(7'b1111111, 3'b000, 1'b0);
    step(B_FETCH, 1'b1);
    step(B_DECODE, 1'b1);
`ifdef ILLEGAL_TRAP_EN
    step(B_TRAP, 1'b1);
    step(B_TRAP, 1'b1);
`else
    step(B_FETCH, 1'b1);
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
